vram_port_arbiter: RTL and testbench

- Memory-side responder for the CPU write queue.
- Owns the single port of the shared vector RAM BRAM and grants it each cycle to one of two clients:
  - a vector-generator (VG) read, or
  - a drained CPU write from the queue.
- Drives the queue's canWrite/writeOut handshake and returns VG read data with fixed 1-cycle latency.
- A starvation counter guarantees queued CPU writes progress while the VG is streaming.

---
 rtl/vram_port_arbiter_pkg.sv | 17 +
 rtl/vram_port_arbiter_if.sv | 52 +++++
 rtl/vram_starve_counter.sv | 46 ++++
 rtl/vram_port_arbiter.sv | 107 ++++++++++
 tb/tb_vram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_port_arbiter_pkg.sv
// Shared definitions for the vector RAM port arbiter.
//   arb_state_t        : last-grant state (no grant / VG read / CPU write)
//   VRAM_BASE/VRAM_SIZE: vector RAM window, matching the BRAM_VECTOR decode range
//   VRAM_MAX_VG_BURST  : default limit of back-to-back VG grants while a write waits
package vram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_VG   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

    localparam logic [15:0] VRAM_BASE         = 16'h2000;
    localparam logic [15:0] VRAM_SIZE         = 16'h2000;
    localparam int          VRAM_MAX_VG_BURST = 7;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the vector RAM port arbiter and its environment.
//   Queue side : wrPending, wrValid, wrAddr, wrData in; canWrite out
//   VG side    : vgReq, vgAddr in; vgGnt, vgValid, vgData out
//   BRAM side  : bramDout in; bramAddr, bramDin, bramWe out
//   Status     : dropCount (saturating dropped-write count), arbState (last grant)
// Modport slave is the arbiter; modport master is the surrounding logic.
interface vram_port_arbiter_if
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();

    logic              wrPending;
    logic              canWrite;
    logic              wrValid;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;

    logic              vgReq;
    logic [ADDR_W-1:0] vgAddr;
    logic              vgGnt;
    logic              vgValid;
    logic [DATA_W-1:0] vgData;

    logic [ADDR_W-4:0] bramAddr;
    logic [DATA_W-1:0] bramDin;
    logic              bramWe;
    logic [DATA_W-1:0] bramDout;

    logic [7:0]        dropCount;
    arb_state_t        arbState;

    modport slave (
        input  wrPending, wrValid, wrAddr, wrData,
        input  vgReq, vgAddr,
        input  bramDout,
        output canWrite, vgGnt, vgValid, vgData,
        output bramAddr, bramDin, bramWe,
        output dropCount, arbState
    );

    modport master (
        output wrPending, wrValid, wrAddr, wrData,
        output vgReq, vgAddr,
        output bramDout,
        input  canWrite, vgGnt, vgValid, vgData,
        input  bramAddr, bramDin, bramWe,
        input  dropCount, arbState
    );

endinterface

// File: rtl/vram_starve_counter.sv
// Counts consecutive VG grants taken while a CPU write is waiting.
//   clk, rst   : clock, asynchronous active-high reset
//   pending    : CPU write queue non-empty
//   vg_gnt     : VG was granted the port this cycle
//   wr_commit  : a CPU write was committed this cycle
//   starve     : counter has reached MAX_BURST; the next slot belongs to the write
module vram_starve_counter
    import vram_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = VRAM_MAX_VG_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    input  logic vg_gnt,
    input  logic wr_commit,
    output logic starve
);

    localparam int                CNT_W   = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        // Only VG grants that actually delay a waiting write are counted.
        if (!pending || wr_commit) begin
            count_next = '0;
        end else if (vg_gnt && (count_reg != MAX_CNT)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign starve = (count_reg == MAX_CNT);

endmodule

// File: rtl/vram_port_arbiter.sv
// Owner of the single vector RAM BRAM port. Each cycle the port goes to
// either a vector-generator read or a drained CPU write from the write queue.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : queue handshake (canWrite/wrValid), VG read channel with
//              1-cycle read latency, BRAM port, dropCount and arbState status
// VG reads win by default; after MAX_VG_BURST VG grants with a write waiting,
// one cycle is handed to the queue so writes always make progress.
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int              ADDR_W       = 16,
    parameter int              DATA_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = VRAM_BASE,
    parameter logic [ADDR_W-1:0] WIN_SIZE   = VRAM_SIZE,
    parameter int              MAX_VG_BURST = VRAM_MAX_VG_BURST
) (
    input  logic             clk,
    input  logic             rst,
    vram_port_arbiter_if.slave bus
);

    localparam int OFF_W = ADDR_W - 3;
    // One extra bit so the window end cannot wrap to zero.
    localparam logic [ADDR_W:0] WIN_END = {1'b0, BASE_ADDR} + {1'b0, WIN_SIZE};

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic             starve;
    logic             can_write;
    logic             vg_gnt;
    logic             wr_commit;
    logic             wr_in_win;
    logic             bram_we;
    logic [OFF_W-1:0] vg_off;
    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] bram_addr_reg;
    logic [OFF_W-1:0] bram_addr_next;
    logic             vg_valid_reg;
    logic [7:0]       drop_reg;
    logic [7:0]       drop_next;

    vram_starve_counter #(
        .MAX_BURST (MAX_VG_BURST)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .pending   (bus.wrPending),
        .vg_gnt    (vg_gnt),
        .wr_commit (wr_commit),
        .starve    (starve)
    );

    // Offsets are taken modulo the window size, so subtracting only the low
    // bits gives the same result as a full-width subtract and truncate.
    assign vg_off    = bus.vgAddr[OFF_W-1:0] - BASE_ADDR[OFF_W-1:0];
    assign wr_off    = bus.wrAddr[OFF_W-1:0] - BASE_ADDR[OFF_W-1:0];
    assign wr_in_win = (bus.wrAddr >= BASE_ADDR) && ({1'b0, bus.wrAddr} < WIN_END);

    always_comb begin
        // canWrite must never look at wrValid: the queue builds wrValid from it.
        can_write      = !rst && (!bus.vgReq || (bus.wrPending && starve));
        vg_gnt         = !rst && bus.vgReq && !can_write;
        wr_commit      = !rst && !vg_gnt && bus.wrValid;
        bram_we        = wr_commit && wr_in_win;
        bram_addr_next = bram_addr_reg;
        drop_next      = drop_reg;
        state_next     = ARB_IDLE;

        if (vg_gnt) begin
            bram_addr_next = vg_off;
            state_next     = ARB_VG;
        end else if (wr_commit) begin
            bram_addr_next = wr_off;
            state_next     = ARB_WR;
            // Out-of-window writes are still popped from the queue, only counted.
            if (!wr_in_win && (drop_reg != 8'hFF)) begin
                drop_next = drop_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            bram_addr_reg <= '0;
            vg_valid_reg  <= 1'b0;
            drop_reg      <= 8'd0;
        end else begin
            state_reg     <= state_next;
            bram_addr_reg <= bram_addr_next;
            vg_valid_reg  <= vg_gnt;
            drop_reg      <= drop_next;
        end
    end

    assign bus.canWrite  = can_write;
    assign bus.vgGnt     = vg_gnt;
    assign bus.bramWe    = bram_we;
    assign bus.bramAddr  = bram_addr_next;
    assign bus.bramDin   = bus.wrData;
    assign bus.vgValid   = vg_valid_reg;
    // BRAM output already carries one cycle of latency, so it is passed through.
    assign bus.vgData    = vg_valid_reg ? bus.bramDout : '0;
    assign bus.dropCount = drop_reg;
    assign bus.arbState  = state_reg;

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;
    import vram_port_arbiter_pkg::*;

    localparam int BASE = 'h2000;
    localparam int SIZE = 'h2000;
    localparam int MAXB = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    vram_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .BASE_ADDR    (16'h2000),
        .WIN_SIZE     (16'h2000),
        .MAX_VG_BURST (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous BRAM model driven by the arbiter's port.
    logic [7:0] bram [0:8191];
    always @(posedge clk) begin
        if (bus.bramWe) bram[bus.bramAddr] <= bus.bramDin;
        bus.bramDout <= bram[bus.bramAddr];
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit          known;
        logic [15:0] addr;
        logic [7:0]  data;
    } rd_t;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [7:0] ref_mem [int];
    wr_t        wq [$];
    rd_t        sb [$];
    int         burst = 0;
    int         drop = 0;
    int         last_off = 0;
    arb_state_t exp_state = ARB_IDLE;
    bit         last_gnt, last_wr;
    int         we_count = 0;
    int         valid_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int off(input logic [15:0] a);
        return (((32'(a) - BASE) % SIZE) + SIZE) % SIZE;
    endfunction

    function automatic bit in_win(input logic [15:0] a);
        return (32'(a) >= BASE) && (32'(a) < BASE + SIZE);
    endfunction

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    // One clock cycle: drive at negedge, let the queue react to canWrite,
    // compare port usage against the model, end right after the posedge.
    task automatic cycle(input bit req, input logic [15:0] addr);
        bit pend, exp_cw, exp_gnt, wr, win;
        rd_t r;
        @(negedge clk);
        pend          = (wq.size() != 0);
        bus.vgReq     = req;
        bus.vgAddr    = addr;
        bus.wrPending = pend;
        bus.wrValid   = 1'b0;
        bus.wrAddr    = pend ? wq[0].addr : 16'h0;
        bus.wrData    = pend ? wq[0].data : 8'h0;
        #1;
        check("arbState", 32'(bus.arbState), 32'(exp_state));
        check("dropCount", 32'(bus.dropCount), 32'(drop));
        exp_cw  = !req || (pend && burst == MAXB);
        exp_gnt = req && !exp_cw;
        check("canWrite", 32'(bus.canWrite), 32'(exp_cw));
        check("vgGnt", 32'(bus.vgGnt), 32'(exp_gnt));
        wr = pend && bus.canWrite;
        bus.wrValid = wr;
        #1;
        if (bus.bramWe === 1'b1) we_count++;
        last_gnt = (bus.vgGnt === 1'b1);
        last_wr  = wr && !exp_gnt;
        if (exp_gnt) begin
            check("bramAddr_rd", 32'(bus.bramAddr), 32'(off(addr)));
            check("bramWe_rd", 32'(bus.bramWe), 32'd0);
            last_off = off(addr);
            r.known = ref_mem.exists(last_off);
            r.addr  = addr;
            r.data  = r.known ? ref_mem[last_off] : 8'h00;
            sb.push_back(r);
            exp_state = ARB_VG;
        end else if (wr) begin
            win = in_win(wq[0].addr);
            check("bramAddr_wr", 32'(bus.bramAddr), 32'(off(wq[0].addr)));
            check("bramWe_wr", 32'(bus.bramWe), 32'(win));
            if (win) begin
                check("bramDin", 32'(bus.bramDin), 32'(wq[0].data));
                ref_mem[off(wq[0].addr)] = wq[0].data;
            end else if (drop < 255) begin
                drop++;
            end
            $display("write addr=0x%04h data=0x%02h %s", wq[0].addr, wq[0].data, win ? "stored" : "dropped");
            last_off  = off(wq[0].addr);
            exp_state = ARB_WR;
        end else begin
            check("bramAddr_hold", 32'(bus.bramAddr), 32'(last_off));
            check("bramWe_idle", 32'(bus.bramWe), 32'd0);
            exp_state = ARB_IDLE;
        end
        if (!pend || last_wr) burst = 0;
        else if (exp_gnt && burst < MAXB) burst++;
        @(posedge clk);
        if (wr) void'(wq.pop_front());
    endtask

    // Monitor: compares every presented read response with the scoreboard.
    initial begin : monitor
        rd_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.vgValid === 1'b1) begin
                valid_seen++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.known) check("vgData", 32'(bus.vgData), 32'(e.data));
                    $display("read addr=0x%04h data=0x%02h", e.addr, bus.vgData);
                end
            end
        end
    end

    initial begin : stim
        int n, grants, wr_at, v0;
        logic [15:0] a, hi;
        bus.vgReq = 1'b0; bus.vgAddr = '0; bus.wrPending = 1'b0;
        bus.wrValid = 1'b0; bus.wrAddr = '0; bus.wrData = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_vgValid", 32'(bus.vgValid), 32'd0);
        check("rst_vgData", 32'(bus.vgData), 32'd0);
        check("rst_dropCount", 32'(bus.dropCount), 32'd0);
        check("rst_arbState", 32'(bus.arbState), 32'(ARB_IDLE));
        check("rst_canWrite", 32'(bus.canWrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_canWrite", 32'(bus.canWrite), 32'd1);

        // Three queued writes drain on consecutive cycles, then read back
        push_wr(16'h2000, 8'hAA);
        push_wr(16'h2001, 8'hBB);
        push_wr(16'h2002, 8'hCC);
        v0 = we_count;
        repeat (3) cycle(1'b0, 16'h0);
        check("drain_we_pulses", 32'(we_count - v0), 32'd3);
        cycle(1'b1, 16'h2000);
        cycle(1'b1, 16'h2001);
        cycle(1'b1, 16'h2002);
        cycle(1'b0, 16'h0);

        // Starvation: VG streaming with one write waiting
        push_wr(16'h2010, 8'h55);
        n = 0; grants = 0; wr_at = -1;
        while (grants < 20 && n < 40) begin
            cycle(1'b1, 16'h2000 + 16'($urandom_range(0, 31)));
            if (last_gnt) grants++;
            if (last_wr) wr_at = n;
            n++;
        end
        check("starve_write_slot", 32'(wr_at), 32'd7);
        check("starve_total_cycles", 32'(n), 32'd21);
        cycle(1'b1, 16'h2010);

        // Back-to-back reads of the same address
        push_wr(16'h2004, 8'h5A);
        cycle(1'b0, 16'h0);
        repeat (3) begin
            cycle(1'b1, 16'h2004);
            #1;
            check("b2b_vgValid", 32'(bus.vgValid), 32'd1);
        end
        cycle(1'b0, 16'h0);

        // Out-of-window writes are dropped and counted, saturating
        push_wr(16'h1200, 8'h11);
        cycle(1'b0, 16'h0);
        #1;
        check("drop_first", 32'(bus.dropCount), 32'd1);
        for (int i = 0; i < 299; i++) push_wr(16'h1200, 8'($urandom));
        n = 0;
        while (wq.size() != 0 && n < 400) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        check("drop_drain_bound", 32'(wq.size()), 32'd0);
        #1;
        check("drop_saturated", 32'(bus.dropCount), 32'd255);

        // Asynchronous reset in the middle of a VG grant
        cycle(1'b1, 16'h2004);
        #3;
        rst = 1'b1;
        bus.wrPending = 1'b1; bus.wrValid = 1'b1;
        bus.wrAddr = 16'h2005; bus.wrData = 8'hEE;
        #1;
        check("arst_vgValid", 32'(bus.vgValid), 32'd0);
        check("arst_dropCount", 32'(bus.dropCount), 32'd0);
        check("arst_arbState", 32'(bus.arbState), 32'(ARB_IDLE));
        check("arst_bramWe", 32'(bus.bramWe), 32'd0);
        check("arst_canWrite", 32'(bus.canWrite), 32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_bramWe", 32'(bus.bramWe), 32'd0);
        check("arst_hold_vgValid", 32'(bus.vgValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.vgReq = 1'b0; bus.wrPending = 1'b0; bus.wrValid = 1'b0;
        sb.delete(); wq.delete();
        burst = 0; drop = 0; last_off = 0; exp_state = ARB_IDLE;

        // No write pending: VG granted every cycle
        grants = 0;
        repeat (30) begin
            cycle(1'b1, 16'h2000 + 16'($urandom_range(0, 31)));
            if (last_gnt) grants++;
        end
        check("nopend_grants", 32'(grants), 32'd30);

        // Randomized traffic, including aliased VG addresses and stray writes
        repeat (1500) begin
            if ($urandom_range(0, 9) < 3 && wq.size() < 8) begin
                if ($urandom_range(0, 99) < 85) a = 16'h2000 + 16'($urandom_range(0, 31));
                else a = 16'($urandom);
                push_wr(a, 8'($urandom));
            end
            case ($urandom_range(0, 5))
                0:       hi = 16'h0000;
                1:       hi = 16'h4000;
                2:       hi = 16'hE000;
                default: hi = 16'h2000;
            endcase
            cycle($urandom_range(0, 9) < 7, hi + 16'($urandom_range(0, 31)));
        end

        n = 0;
        while (wq.size() != 0 && n < 50) begin
            cycle(1'b0, 16'h0);
            n++;
        end
        cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("final_queue_empty", 32'(wq.size()), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
